// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcodes, functs, ALU codes, FSM states, mux selects, instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MUL  = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // REGIMM rt field selecting bgez
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_ADDU = 4'd11,
        ALU_SUBU = 4'd12
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        DEST_RT = 2'd0,
        DEST_RD = 2'd1,
        DEST_RA = 2'd2
    } dest_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'd0,
        PCS_BRANCH = 2'd1,
        PCS_JUMP   = 2'd2,
        PCS_RS     = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_RT   = 2'd0,
        SRCB_FOUR = 2'd1,
        SRCB_SEXT = 2'd2,
        SRCB_ZEXT = 2'd3
    } src_b_e;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_MUL   = 4'd1,
        CL_JR    = 4'd2,
        CL_IMM_S = 4'd3,
        CL_IMM_Z = 4'd4,
        CL_LW    = 4'd5,
        CL_SW    = 4'd6,
        CL_BEQ   = 4'd7,
        CL_BNE   = 4'd8,
        CL_BGEZ  = 4'd9,
        CL_BGTZ  = 4'd10,
        CL_J     = 4'd11,
        CL_JAL   = 4'd12
    } cls_e;

    // Second ALU operand used while the instruction executes / writes back
    function automatic src_b_e exec_src_b(input cls_e c);
        case (c)
            CL_IMM_Z:               return SRCB_ZEXT;
            CL_IMM_S, CL_LW, CL_SW: return SRCB_SEXT;
            default:                return SRCB_RT;
        endcase
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational decoder: latched opcode/funct/rt -> instruction class,
// ALU code and legal flag. Ports: opcode, funct, rt in; cls, alu, legal out.
module mips_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output logic [3:0] cls,
    output logic [3:0] alu,
    output logic       legal
);

    always_comb begin
        cls   = CL_RTYPE;
        alu   = ALU_ADD;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:  alu = ALU_SLL;
                    FN_SRL:  alu = ALU_SRL;
                    FN_SRA:  alu = ALU_SRA;
                    FN_ADD:  alu = ALU_ADD;
                    FN_ADDU: alu = ALU_ADDU;
                    FN_SUB:  alu = ALU_SUB;
                    FN_SUBU: alu = ALU_SUBU;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_NOR:  alu = ALU_NOR;
                    FN_SLT:  alu = ALU_SLT;
                    FN_JR:   cls = CL_JR;
                    FN_MUL: begin
                        cls = CL_MUL;
                        alu = ALU_MUL;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                cls   = CL_BGEZ;
                alu   = ALU_SUB;
                legal = (rt == RT_BGEZ);
            end
            OP_J:   cls = CL_J;
            OP_JAL: cls = CL_JAL;
            OP_BEQ: begin
                cls = CL_BEQ;
                alu = ALU_SUB;
            end
            OP_BNE: begin
                cls = CL_BNE;
                alu = ALU_SUB;
            end
            OP_BGTZ: begin
                cls = CL_BGTZ;
                alu = ALU_SUB;
            end
            OP_ADDI: cls = CL_IMM_S;
            OP_ADDIU: begin
                cls = CL_IMM_S;
                alu = ALU_ADDU;
            end
            OP_SLTI: begin
                cls = CL_IMM_S;
                alu = ALU_SLT;
            end
            OP_ANDI: begin
                cls = CL_IMM_Z;
                alu = ALU_AND;
            end
            OP_ORI: begin
                cls = CL_IMM_Z;
                alu = ALU_OR;
            end
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM control unit: FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB/TRAP.
// In: CLOCK, RESET_N, instruction, zero, neg, MEM_READY. Out: datapath enables/selects, BUSY, ILLEGAL.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_W      = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             neg,
    input  logic             MEM_READY,
    output logic             PC_W,
    output logic             IR_W,
    output logic             MEM_R,
    output logic             MEM_W,
    output logic             REG_W,
    output logic [1:0]       DEST,
    output logic             MEM_TO_REG,
    output logic             ALU_SRC_A,
    output logic [1:0]       ALU_SRC_B,
    output logic [1:0]       PC_SRC,
    output logic [ALU_W-1:0] ALU,
    output logic             BUSY,
    output logic             ILLEGAL
);

    state_e     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [5:0] op_q, fn_q;
    logic [4:0] rt_q;

    logic [3:0] dec_cls, dec_alu;
    logic       legal;
    cls_e       cls;
    alu_op_e    op_alu;

    alu_op_e    alu_sel;
    dest_e      dest_sel;
    pc_src_e    pcs_sel;
    src_b_e     srcb_sel;
    logic       take;

    logic       unused_bits;
    assign unused_bits = ^{instruction[25:21], instruction[15:6]};

    mips_decode u_dec (
        .opcode (op_q),
        .funct  (fn_q),
        .rt     (rt_q),
        .cls    (dec_cls),
        .alu    (dec_alu),
        .legal  (legal)
    );

    assign cls    = cls_e'(dec_cls);
    assign op_alu = alu_op_e'(dec_alu);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_FETCH;
            cnt   <= '0;
            op_q  <= '0;
            fn_q  <= '0;
            rt_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // rt is kept too so the bgez check never looks at stale bus data
            if (state == S_FETCH && MEM_READY) begin
                op_q <= instruction[31:26];
                fn_q <= instruction[5:0];
                rt_q <= instruction[20:16];
            end
        end
    end

    always_comb begin
        case (cls)
            CL_BEQ:  take = zero;
            CL_BNE:  take = !zero;
            CL_BGEZ: take = !neg;
            CL_BGTZ: take = !neg && !zero;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        PC_W       = 1'b0;
        IR_W       = 1'b0;
        MEM_R      = 1'b0;
        MEM_W      = 1'b0;
        REG_W      = 1'b0;
        MEM_TO_REG = 1'b0;
        ALU_SRC_A  = 1'b0;
        dest_sel   = DEST_RT;
        pcs_sel    = PCS_ALU;
        srcb_sel   = SRCB_RT;
        alu_sel    = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                MEM_R    = 1'b1;
                srcb_sel = SRCB_FOUR;
                // reset holds the capture strobes low even if memory is ready
                if (MEM_READY && RESET_N) begin
                    IR_W    = 1'b1;
                    PC_W    = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                srcb_sel = SRCB_SEXT;
                if (!legal) begin
                    state_n = S_TRAP;
                end else begin
                    case (cls)
                        CL_J: begin
                            PC_W    = 1'b1;
                            pcs_sel = PCS_JUMP;
                            state_n = S_FETCH;
                        end
                        CL_JAL: begin
                            PC_W     = 1'b1;
                            pcs_sel  = PCS_JUMP;
                            REG_W    = 1'b1;
                            dest_sel = DEST_RA;
                            state_n  = S_FETCH;
                        end
                        CL_JR: begin
                            PC_W    = 1'b1;
                            pcs_sel = PCS_RS;
                            state_n = S_FETCH;
                        end
                        default: state_n = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                ALU_SRC_A = 1'b1;
                srcb_sel  = exec_src_b(cls);
                alu_sel   = op_alu;
                case (cls)
                    CL_BEQ, CL_BNE, CL_BGEZ, CL_BGTZ: begin
                        PC_W    = take;
                        pcs_sel = take ? PCS_BRANCH : PCS_ALU;
                        state_n = S_FETCH;
                    end
                    CL_MUL: begin
                        if (MUL_CYCLES > 1) begin
                            cnt_n   = 4'(MUL_CYCLES - 1);
                            state_n = S_MUL_WAIT;
                        end else begin
                            state_n = S_WB;
                        end
                    end
                    CL_LW, CL_SW: state_n = S_MEM;
                    default:      state_n = S_WB;
                endcase
            end
            S_MUL_WAIT: begin
                ALU_SRC_A = 1'b1;
                alu_sel   = ALU_MUL;
                if (cnt <= 4'd1) begin
                    cnt_n   = '0;
                    state_n = S_WB;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_MEM: begin
                ALU_SRC_A = 1'b1;
                srcb_sel  = SRCB_SEXT;
                MEM_R     = (cls == CL_LW);
                MEM_W     = (cls == CL_SW);
                if (MEM_READY) begin
                    state_n = (cls == CL_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                ALU_SRC_A  = 1'b1;
                srcb_sel   = exec_src_b(cls);
                alu_sel    = op_alu;
                REG_W      = 1'b1;
                MEM_TO_REG = (cls == CL_LW);
                if (cls == CL_RTYPE || cls == CL_MUL) begin
                    dest_sel = DEST_RD;
                end
                state_n = S_FETCH;
            end
            S_TRAP: state_n = S_TRAP;
            default: state_n = S_FETCH;
        endcase
    end

    assign DEST      = dest_sel;
    assign PC_SRC    = pcs_sel;
    assign ALU_SRC_B = srcb_sel;
    assign ALU       = ALU_W'(alu_sel);
    assign BUSY      = (state != S_FETCH);
    assign ILLEGAL   = (state == S_TRAP);

endmodule
